bypass_pipe_net: RTL and testbench
==================================

BYPASS_PIPE_NET -- requirements
Module: bypass_pipe_net

Interface
REQ-001 SHALL have parameter WIDTH, default 4, the number of writeback source ports.
REQ-002 SHALL have parameter NREAD, default 8, the number of operand read ports.
REQ-003 SHALL have parameter DEPTH, default 2, the number of registered history stages; 0 is legal.
REQ-004 SHALL have port clk  input  1  the single clock; all state is on the rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port i_wb_vld  input  WIDTH  per-port writeback valid.
REQ-007 SHALL have port i_wb_idx  input  iprIdx_t[WIDTH]  writeback physical register index.
REQ-008 SHALL have port i_wb_data  input  XDEF[WIDTH]  writeback data.
REQ-009 SHALL have port i_flush  input  1  clears all registered history.
REQ-010 SHALL have port i_rd_idx  input  iprIdx_t[NREAD]  operand index to look up.
REQ-011 SHALL have port o_rd_vld  output  NREAD  per-port bypass hit.
REQ-012 SHALL have port o_rd_data  output  XDEF[NREAD]  per-port bypass data.
REQ-013 SHALL have port o_multihit  output  1  sticky duplicate-index error; present only with the macro in REQ-028.

Function
REQ-014 SHALL treat the current-cycle i_wb_* as stage 0, which is combinational and unregistered.
REQ-015 SHALL hold registered stages 1..DEPTH, each holding WIDTH {vld, idx, data} entries.
REQ-016 SHALL shift the stages every cycle: stage k+1 <= stage k, and stage 1 <= stage 0; the stage-DEPTH contents are discarded.
REQ-017 SHALL make a writeback presented in cycle t hit in cycles t through t+DEPTH inclusive, and never after.
REQ-018 SHALL resolve each read port as hit = any valid entry with idx == i_rd_idx, in any stage 0..DEPTH.
REQ-019 SHALL give priority to the youngest stage on a match in more than one stage: stage 0 over stage 1 over … over stage DEPTH.
REQ-020 SHALL drive o_rd_vld=0 and o_rd_data=0 when a read port has no hit.
REQ-021 SHALL never hit on index 0, which is hardwired zero, regardless of any writeback to index 0.
REQ-022 SHALL clear the valid bits of stages 1..DEPTH at the next edge when i_flush=1; the same-cycle writeback is also not captured.
REQ-023 SHALL still forward stage 0 combinationally during a flush cycle.
REQ-024 SHALL reduce to a purely combinational lookup of stage 0 when DEPTH=0, with no registers.
REQ-025 SHALL give every read port identical, independent lookup logic.

Reset
REQ-026 SHALL, while rst=1, asynchronously clear every stage valid bit, idx and data to 0, and clear o_multihit to 0.
REQ-027 SHALL hold all outputs at o_rd_vld=0, o_rd_data=0 and o_multihit=0 during reset; stage 0 is masked by rst.

Configuration
REQ-028 SHALL use the macro BYPASS_MULTIHIT_CHK_EN.
REQ-029 SHALL, when BYPASS_MULTIHIT_CHK_EN is defined:
- set o_multihit sticky when two valid, nonzero, equal indices exist within any one stage 0..DEPTH;
- clear o_multihit only by rst;
- flag the same condition with a simulation assertion.
REQ-030 SHALL, when BYPASS_MULTIHIT_CHK_EN is undefined, omit the o_multihit port, its detection logic and the assertion.
REQ-031 SHALL, when BYPASS_MULTIHIT_CHK_EN is undefined, resolve an intra-stage duplicate to the highest-numbered writeback port.

Structure
REQ-032 SHALL take iprIdx_t and the XDEF width from the shared core package/define header.
REQ-033 SHALL define a bypass_entry_t struct {vld, idx, data} in that same shared package.
REQ-034 SHALL use one sub-module, bypass_stage_match, which matches one index against the WIDTH entries of one stage and returns {hit, data, dup}.
REQ-035 SHALL instantiate bypass_stage_match once per (stage, read port), and do the priority resolution in the top module.

Verification
REQ-036 SHALL cover latency: wb port0 idx=5, data=0xAA in cycle 0 -> rd idx=5 hits 0xAA in cycles 0, 1 and 2 with DEPTH=2; misses in cycle 3.
REQ-037 SHALL cover priority: idx=7 data=0x1 in cycle 0, then idx=7 data=0x2 in cycle 1 -> rd idx=7 returns 0x2 in cycle 1 and in cycle 2.
REQ-038 SHALL cover flush: idx=9 written in cycle 0 with i_flush=1 in cycle 1:
- cycle 1: rd idx=9 still hits;
- cycle 2: rd idx=9 misses;
- cycle 2: a new wb idx=9 presented that cycle hits.
REQ-039 SHALL cover the zero register: wb idx=0 data=0xFF -> every read of idx=0 returns vld=0, data=0 in all cycles.
REQ-040 SHALL cover multi-hit with the macro: port1 and port3 both write idx=12 in the same cycle -> o_multihit=1 from the next edge; it stays 1 until rst.
REQ-041 SHALL cover async reset mid-operation: rst pulsed between edges while history is valid -> o_rd_vld=0 immediately; after release all prior indices miss.

Source files
------------

// File: rtl/bypass_pipe_net_pkg.sv
// Shared core types for the writeback bypass network: physical register index,
// datapath word and the {vld, idx, data} history entry.
package bypass_pipe_net_pkg;

  localparam int IPR_IDX_W = 6;
  localparam int XDEF      = 64;

  typedef logic [IPR_IDX_W-1:0] iprIdx_t;
  typedef logic [XDEF-1:0]      xdef_t;

  typedef struct packed {
    logic    vld;
    iprIdx_t idx;
    xdef_t   data;
  } bypass_entry_t;

  // Index 0 is the hardwired zero register and never participates in a match.
  function automatic logic entry_matches(bypass_entry_t e, iprIdx_t idx);
    return e.vld && (e.idx != '0) && (e.idx == idx);
  endfunction

endpackage

// File: rtl/bypass_pipe_net_stage_match.sv
// Matches one lookup index against the WIDTH entries of one bypass stage.
// With BYPASS_MULTIHIT_CHK_EN the stage is also scanned for duplicate live indices.
module bypass_stage_match
  import bypass_pipe_net_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  bypass_entry_t entries [WIDTH],
  input  iprIdx_t       rd_idx,
  output logic          hit,
  output xdef_t         data
`ifdef BYPASS_MULTIHIT_CHK_EN
  ,
  output logic          dup
`endif
);

  // Ascending scan so the highest-numbered matching port wins a duplicate.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int j = 0; j < WIDTH; j++) begin
      if (entry_matches(entries[j], rd_idx)) begin
        hit  = 1'b1;
        data = entries[j].data;
      end
    end
  end

`ifdef BYPASS_MULTIHIT_CHK_EN
  always_comb begin
    dup = 1'b0;
    for (int a = 0; a < WIDTH; a++) begin
      for (int b = a + 1; b < WIDTH; b++) begin
        if (entries[a].vld && entry_matches(entries[b], entries[a].idx)) begin
          dup = 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: rtl/bypass_pipe_net.sv
// Writeback bypass network: stage 0 is the live writeback bus, stages 1..DEPTH
// are registered history. Optional BYPASS_MULTIHIT_CHK_EN adds o_multihit.
module bypass_pipe_net
  import bypass_pipe_net_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NREAD = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_wb_vld,
  input  iprIdx_t          i_wb_idx  [WIDTH],
  input  xdef_t            i_wb_data [WIDTH],
  input  logic             i_flush,
  input  iprIdx_t          i_rd_idx  [NREAD],
  output logic [NREAD-1:0] o_rd_vld,
  output xdef_t            o_rd_data [NREAD]
`ifdef BYPASS_MULTIHIT_CHK_EN
  ,
  output logic             o_multihit
`endif
);

  bypass_entry_t stage_all [DEPTH+1][WIDTH];
  logic          hit_m     [DEPTH+1][NREAD];
  xdef_t         data_m    [DEPTH+1][NREAD];
`ifdef BYPASS_MULTIHIT_CHK_EN
  logic          dup_m     [DEPTH+1][NREAD];
`endif

  genvar gi, gj;

  // Stage 0 is masked by rst so outputs are quiet throughout reset.
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_stage0
      assign stage_all[0][gi] = {i_wb_vld[gi] & ~rst, i_wb_idx[gi], i_wb_data[gi]};
    end
  endgenerate

  generate
    if (DEPTH > 0) begin : g_hist
      bypass_entry_t hist_reg [DEPTH][WIDTH];

      // hist_reg[k] holds stage k+1; a flush drops every valid bit, including
      // the writeback being captured on that same edge.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < DEPTH; k++) begin
            for (int j = 0; j < WIDTH; j++) begin
              hist_reg[k][j] <= '0;
            end
          end
        end else begin
          for (int k = 0; k < DEPTH; k++) begin
            for (int j = 0; j < WIDTH; j++) begin
              hist_reg[k][j] <= stage_all[k][j];
              if (i_flush) begin
                hist_reg[k][j].vld <= 1'b0;
              end
            end
          end
        end
      end

      for (gi = 1; gi <= DEPTH; gi++) begin : g_tap
        for (gj = 0; gj < WIDTH; gj++) begin : g_ent
          assign stage_all[gi][gj] = hist_reg[gi-1][gj];
        end
      end
    end
  endgenerate

  generate
    for (gi = 0; gi <= DEPTH; gi++) begin : g_s
      for (gj = 0; gj < NREAD; gj++) begin : g_r
        bypass_stage_match #(
          .WIDTH (WIDTH)
        ) u_match (
          .entries (stage_all[gi]),
          .rd_idx  (i_rd_idx[gj]),
          .hit     (hit_m[gi][gj]),
          .data    (data_m[gi][gj])
`ifdef BYPASS_MULTIHIT_CHK_EN
          ,
          .dup     (dup_m[gi][gj])
`endif
        );
      end
    end
  endgenerate

  // Oldest-to-youngest sweep so the youngest matching stage has the last word.
  generate
    for (gj = 0; gj < NREAD; gj++) begin : g_prio
      logic  vld_sel;
      xdef_t data_sel;

      always_comb begin
        vld_sel  = 1'b0;
        data_sel = '0;
        for (int s = DEPTH; s >= 0; s--) begin
          if (hit_m[s][gj]) begin
            vld_sel  = 1'b1;
            data_sel = data_m[s][gj];
          end
        end
      end

      assign o_rd_vld[gj]  = vld_sel;
      assign o_rd_data[gj] = data_sel;
    end
  endgenerate

`ifdef BYPASS_MULTIHIT_CHK_EN
  logic any_dup;
  logic multihit_reg;

  always_comb begin
    any_dup = 1'b0;
    for (int s = 0; s <= DEPTH; s++) begin
      for (int r = 0; r < NREAD; r++) begin
        any_dup = any_dup | dup_m[s][r];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      multihit_reg <= 1'b0;
    end else if (any_dup) begin
      multihit_reg <= 1'b1;
    end
  end

  assign o_multihit = multihit_reg;

  a_no_multihit : assert property (@(posedge clk) disable iff (rst) !any_dup)
    else $warning("bypass_pipe_net: duplicate live index within one bypass stage");
`endif

endmodule

// File: tb/tb_bypass_pipe_net.sv
// Directed bench for bypass_pipe_net (WIDTH=4, NREAD=8, DEPTH=2); the
// BYPASS_MULTIHIT_CHK_EN build swaps the duplicate-resolution test for o_multihit.
module tb_bypass_pipe_net;
  import bypass_pipe_net_pkg::*;

  localparam int WIDTH = 4;
  localparam int NREAD = 8;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] i_wb_vld;
  iprIdx_t          i_wb_idx  [WIDTH];
  xdef_t            i_wb_data [WIDTH];
  logic             i_flush;
  iprIdx_t          i_rd_idx  [NREAD];
  logic [NREAD-1:0] o_rd_vld;
  xdef_t            o_rd_data [NREAD];
`ifdef BYPASS_MULTIHIT_CHK_EN
  logic             o_multihit;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bypass_pipe_net #(
    .WIDTH (WIDTH),
    .NREAD (NREAD),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_wb_vld  (i_wb_vld),
    .i_wb_idx  (i_wb_idx),
    .i_wb_data (i_wb_data),
    .i_flush   (i_flush),
    .i_rd_idx  (i_rd_idx),
    .o_rd_vld  (o_rd_vld),
    .o_rd_data (o_rd_data)
`ifdef BYPASS_MULTIHIT_CHK_EN
    ,
    .o_multihit(o_multihit)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic expect_rd(input string tag, input logic [2:0] p, input logic v, input xdef_t d);
    check_eq({tag, ".vld"}, {63'd0, o_rd_vld[p]}, {63'd0, v});
    check_eq({tag, ".data"}, o_rd_data[p], d);
  endtask

  task automatic idle();
    i_wb_vld = '0;
    i_flush  = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      i_wb_idx[i]  = '0;
      i_wb_data[i] = '0;
    end
  endtask

  task automatic wb(input logic [1:0] p, input iprIdx_t idx, input xdef_t data);
    i_wb_vld[p]  = 1'b1;
    i_wb_idx[p]  = idx;
    i_wb_data[p] = data;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    for (int i = 0; i < NREAD; i++) i_rd_idx[i] = '0;

    // Reset: stage 0 must be masked while rst is high
    repeat (2) @(posedge clk);
    #1;
    wb(2'd0, 6'd5, 64'h55);
    i_rd_idx[0] = 6'd5;
    settle();
    expect_rd("rst_stage0_masked", 3'd0, 1'b0, 64'h0);
    check_eq("rst_all_vld", {56'd0, o_rd_vld}, 64'h0);
`ifdef BYPASS_MULTIHIT_CHK_EN
    check_eq("rst_multihit", {63'd0, o_multihit}, 64'h0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();

    // Latency: hit in cycles 0..DEPTH, miss afterwards
    next_cycle();
    wb(2'd0, 6'd5, 64'hAA);
    i_rd_idx[0] = 6'd5;
    i_rd_idx[3] = 6'd5;
    i_rd_idx[1] = 6'd6;
    settle();
    expect_rd("lat_c0", 3'd0, 1'b1, 64'hAA);
    expect_rd("lat_c0_p3", 3'd3, 1'b1, 64'hAA);
    expect_rd("lat_c0_other_idx", 3'd1, 1'b0, 64'h0);
    next_cycle(); settle();
    expect_rd("lat_c1", 3'd0, 1'b1, 64'hAA);
    next_cycle(); settle();
    expect_rd("lat_c2", 3'd0, 1'b1, 64'hAA);
    next_cycle(); settle();
    expect_rd("lat_c3_miss", 3'd0, 1'b0, 64'h0);

    // Priority: the younger write of idx 7 wins across stages
    i_rd_idx[2] = 6'd7;
    next_cycle();
    wb(2'd2, 6'd7, 64'h1);
    settle();
    expect_rd("prio_c0", 3'd2, 1'b1, 64'h1);
    next_cycle();
    wb(2'd0, 6'd7, 64'h2);
    settle();
    expect_rd("prio_c1", 3'd2, 1'b1, 64'h2);
    next_cycle(); settle();
    expect_rd("prio_c2", 3'd2, 1'b1, 64'h2);
    next_cycle(); settle();
    expect_rd("prio_c3", 3'd2, 1'b1, 64'h2);
    next_cycle(); settle();
    expect_rd("prio_c4_miss", 3'd2, 1'b0, 64'h0);

    // Flush: history cleared at the next edge, stage 0 still forwarded
    i_rd_idx[0] = 6'd9;
    i_rd_idx[1] = 6'd10;
    next_cycle();
    wb(2'd0, 6'd9, 64'h99);
    settle();
    expect_rd("flush_c0", 3'd0, 1'b1, 64'h99);
    next_cycle();
    i_flush = 1'b1;
    wb(2'd1, 6'd10, 64'h10);
    settle();
    expect_rd("flush_c1_hist", 3'd0, 1'b1, 64'h99);
    expect_rd("flush_c1_stage0", 3'd1, 1'b1, 64'h10);
    next_cycle(); settle();
    expect_rd("flush_c2_miss", 3'd0, 1'b0, 64'h0);
    expect_rd("flush_c2_not_captured", 3'd1, 1'b0, 64'h0);
    wb(2'd2, 6'd9, 64'h9A);
    settle();
    expect_rd("flush_c2_new_wb", 3'd0, 1'b1, 64'h9A);
    next_cycle(); settle();
    expect_rd("flush_c3_new_hist", 3'd0, 1'b1, 64'h9A);

    // Zero register never hits
    i_rd_idx[5] = 6'd0;
    i_rd_idx[7] = 6'd0;
    next_cycle();
    wb(2'd0, 6'd0, 64'hFF);
    wb(2'd3, 6'd0, 64'hFE);
    settle();
    expect_rd("zero_c0_p5", 3'd5, 1'b0, 64'h0);
    expect_rd("zero_c0_p7", 3'd7, 1'b0, 64'h0);
    next_cycle(); settle();
    expect_rd("zero_c1", 3'd5, 1'b0, 64'h0);
    next_cycle(); settle();
    expect_rd("zero_c2", 3'd7, 1'b0, 64'h0);

    // Same index on two ports in one cycle
    i_rd_idx[6] = 6'd12;
    next_cycle();
    wb(2'd1, 6'd12, 64'h11);
    wb(2'd3, 6'd12, 64'h33);
    settle();
`ifdef BYPASS_MULTIHIT_CHK_EN
    check_eq("multihit_c0", {63'd0, o_multihit}, 64'h0);
    next_cycle(); settle();
    check_eq("multihit_c1", {63'd0, o_multihit}, 64'h1);
    repeat (3) next_cycle();
    settle();
    check_eq("multihit_sticky", {63'd0, o_multihit}, 64'h1);
`else
    expect_rd("dup_c0_high_port", 3'd6, 1'b1, 64'h33);
    next_cycle(); settle();
    expect_rd("dup_c1_high_port", 3'd6, 1'b1, 64'h33);
    repeat (2) next_cycle();
`endif

    // Asynchronous reset pulse between edges
    i_rd_idx[4] = 6'd20;
    next_cycle();
    wb(2'd0, 6'd20, 64'h20);
    settle();
    expect_rd("arst_c0", 3'd4, 1'b1, 64'h20);
    next_cycle(); settle();
    expect_rd("arst_c1", 3'd4, 1'b1, 64'h20);
    rst = 1'b1;
    #1;
    expect_rd("arst_during", 3'd4, 1'b0, 64'h0);
    check_eq("arst_during_all_vld", {56'd0, o_rd_vld}, 64'h0);
`ifdef BYPASS_MULTIHIT_CHK_EN
    check_eq("arst_multihit_clear", {63'd0, o_multihit}, 64'h0);
`endif
    #1;
    rst = 1'b0;
    #1;
    expect_rd("arst_after", 3'd4, 1'b0, 64'h0);
    next_cycle(); settle();
    expect_rd("arst_after_next", 3'd4, 1'b0, 64'h0);
    expect_rd("arst_old_idx9", 3'd0, 1'b0, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
